// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - command FIFO feeding an external combinational ALU, one result per two cycles
// Results are held until the consumer accepts them.
module alu_op_sequencer #(
  parameter int FIFO_DEPTH = 4,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_a,
  input  logic [3:0]    cmd_b,
  input  logic [2:0]    cmd_op,
  output logic [3:0]    alu_a,
  output logic [3:0]    alu_b,
  output logic [2:0]    alu_op,
  input  logic [3:0]    alu_result,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [3:0]    rsp_result,
  output logic [2:0]    rsp_op,
  output logic [CW-1:0] fifo_count,
  output logic          err_illegal_op
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t        state;
  logic [10:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [10:0]   head;
  logic          push;
  logic          pop;
  logic          illegal;
  logic          not_empty;

  assign cmd_ready = (fifo_count < CW'(FIFO_DEPTH));
  assign push      = cmd_valid & cmd_ready & (cmd_op <= 3'd4);
  assign illegal   = cmd_valid & cmd_ready & (cmd_op > 3'd4);
  assign not_empty = (fifo_count != '0);
  assign head      = mem[rd_ptr];

  // The head leaves the FIFO only when the ALU stage is free: idle, or its held result is being accepted.
  assign pop = not_empty & ((state == IDLE) | ((state == HOLD) & rsp_ready));

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_a, cmd_b, cmd_op};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_illegal_op <= 1'b0;
    end else begin
      err_illegal_op <= illegal;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_op     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            {alu_a, alu_b, alu_op} <= head;
            state                  <= DRIVE;
          end
        end
        DRIVE: begin
          rsp_result <= alu_result;
          rsp_op     <= alu_op;
          rsp_valid  <= 1'b1;
          state      <= HOLD;
        end
        HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (pop) begin
              {alu_a, alu_b, alu_op} <= head;
              state                  <= DRIVE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - scoreboard bench for alu_op_sequencer with a 4-bit behavioural ALU
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a, cmd_b;
  logic [2:0] cmd_op;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic [3:0] alu_result;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_result;
  logic [2:0] rsp_op;
  logic [2:0] fifo_count;
  logic       err_illegal_op;

  always #5 clk = ~clk;

  alu_op_sequencer #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_op(rsp_op),
    .fifo_count(fifo_count), .err_illegal_op(err_illegal_op)
  );

  // Downstream combinational ALU
  always_comb begin
    alu_result = 4'd0;
    case (alu_op)
      3'd0: alu_result = alu_a + alu_b;
      3'd1: alu_result = alu_a - alu_b;
      3'd2: alu_result = alu_a & alu_b;
      3'd3: alu_result = alu_a | alu_b;
      3'd4: alu_result = alu_a ^ alu_b;
      default: alu_result = 4'd0;
    endcase
  end

  typedef struct {
    int res;
    int op;
  } exp_t;

  exp_t q[$];
  int   hs_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pend_err = 0;
  int   prev_valid = 0;
  int   prev_hs = 0;
  int   prev_data = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int a, input int b, input int op);
    exp_t e;
    e.op = op;
    case (op)
      0: e.res = (a + b) % 16;
      1: e.res = (a - b + 16) % 16;
      2: e.res = a & b;
      3: e.res = a | b;
      default: e.res = a ^ b;
    endcase
    return e;
  endfunction

  // Monitor: predicts from accepted commands, checks on every response handshake
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      pend_err = 0;
      prev_valid = 0;
      prev_hs = 0;
    end else begin
      if (pend_err != 0 || err_illegal_op)
        check("err_pulse", int'(err_illegal_op), pend_err);
      if (prev_valid != 0 && prev_hs == 0) begin
        check("hold_valid", int'(rsp_valid), 1);
        check("hold_stable", int'({rsp_result, rsp_op}), prev_data);
      end
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) begin
          check("unexpected_rsp", int'(rsp_result), -1);
        end else begin
          e = q.pop_front();
          check("rsp_result", int'(rsp_result), e.res);
          check("rsp_op", int'(rsp_op), e.op);
        end
        hs_cyc.push_back(cyc);
      end
      if (cmd_valid && cmd_ready && cmd_op <= 3'd4)
        q.push_back(model(int'(cmd_a), int'(cmd_b), int'(cmd_op)));
      pend_err = (cmd_valid && cmd_ready && cmd_op > 3'd4) ? 1 : 0;
      prev_valid = int'(rsp_valid);
      prev_hs = (rsp_valid && rsp_ready) ? 1 : 0;
      prev_data = int'({rsp_result, rsp_op});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int a, input int b, input int op);
    cmd_valid = 1'b1;
    cmd_a = a[3:0];
    cmd_b = b[3:0];
    cmd_op = op[2:0];
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fifo_count"}, int'(fifo_count), 0);
    check({tag, "_cmd_ready"}, int'(cmd_ready), 1);
    check({tag, "_alu"}, int'({alu_a, alu_b, alu_op}), 0);
    check({tag, "_rsp_valid"}, int'(rsp_valid), 0);
    check({tag, "_rsp_data"}, int'({rsp_result, rsp_op}), 0);
    check({tag, "_err"}, int'(err_illegal_op), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int peak;
    int n0;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_a = '0;
    cmd_b = '0;
    cmd_op = '0;
    rsp_ready = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // Single command latency: push at N, pop at N+1, rsp_valid at N+2
    rsp_ready = 1'b1;
    send(4, 2, 0);
    @(negedge clk);
    check("lat_count_n", int'(fifo_count), 1);
    check("lat_valid_n", int'(rsp_valid), 0);
    tick();
    @(negedge clk);
    check("lat_count_n1", int'(fifo_count), 0);
    check("lat_alu_n1", int'({alu_a, alu_b, alu_op}), {4'd4, 4'd2, 3'd0});
    check("lat_valid_n1", int'(rsp_valid), 0);
    tick();
    @(negedge clk);
    check("lat_valid_n2", int'(rsp_valid), 1);
    repeat (3) tick();

    // Back-to-back stream with consumer ready
    peak = 0;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1;
      cmd_a = (i == 0) ? 4'd7 : (i == 3) ? 4'd8 : 4'd5;
      cmd_b = (i == 0) ? 4'd3 : (i == 3) ? 4'd9 : 4'd6;
      cmd_op = 3'(i + 1);
      @(negedge clk);
      check("b2b_cmd_ready", int'(cmd_ready), 1);
      tick();
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
    cmd_valid = 1'b0;
    check("b2b_peak", peak, 2);
    repeat (10) tick();

    // Consumer stalled: one in HOLD plus four queued, sixth command refused
    rsp_ready = 1'b0;
    n0 = hs_cyc.size();
    for (int i = 0; i < 5; i++) send(i + 1, 2 * i + 3, i % 5);
    @(negedge clk);
    check("full_count", int'(fifo_count), 4);
    check("full_cmd_ready", int'(cmd_ready), 0);
    check("full_rsp_valid", int'(rsp_valid), 1);
    send(9, 9, 0);
    @(negedge clk);
    check("full_ignored_count", int'(fifo_count), 4);
    check("full_no_err", int'(err_illegal_op), 0);
    rsp_ready = 1'b1;
    repeat (14) tick();
    check("full_drained", hs_cyc.size() - n0, 5);
    for (int i = n0 + 1; i < hs_cyc.size(); i++)
      check("throughput_gap", hs_cyc[i] - hs_cyc[i-1], 2);

    // Illegal opcode
    send(3, 3, 6);
    @(negedge clk);
    check("illegal_err", int'(err_illegal_op), 1);
    check("illegal_count", int'(fifo_count), 0);
    tick();
    @(negedge clk);
    check("illegal_err_clear", int'(err_illegal_op), 0);
    check("illegal_no_rsp", int'(rsp_valid), 0);
    repeat (2) tick();

    // Wraparound results
    send(15, 1, 0);
    send(0, 1, 1);
    repeat (8) tick();

    // Reset while the first of three commands is in DRIVE
    rsp_ready = 1'b0;
    send(1, 2, 0);
    send(3, 4, 1);
    cmd_valid = 1'b1;
    cmd_a = 4'd5;
    cmd_b = 4'd6;
    cmd_op = 3'd2;
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("midrst_no_stale", int'(rsp_valid), 0);
      tick();
    end

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_a = 4'($urandom_range(0, 15));
      cmd_b = 4'($urandom_range(0, 15));
      cmd_op = 3'($urandom_range(0, 7));
      rsp_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (20) tick();
    check("drain_empty", q.size(), 0);
    check("drain_count", int'(fifo_count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port cmd_valid  input  1  upstream command present.
REQ-005 SHALL have port cmd_ready  output  1  FIFO can accept a command.
REQ-006 SHALL have ports cmd_a, cmd_b  input  4 each  operands.
REQ-007 SHALL have port cmd_op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR.
REQ-008 SHALL have ports alu_a, alu_b  output  4 each  registered operands to downstream combinational ALU.
REQ-009 SHALL have port alu_op  output  3  registered opcode to ALU.
REQ-010 SHALL have port alu_result  input  4  ALU combinational result.
REQ-011 SHALL have port rsp_valid  output  1  captured result available.
REQ-012 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-013 SHALL have ports rsp_result  output  4  and rsp_op  output  3  captured result and its opcode.
REQ-014 SHALL have port fifo_count  output  log2(FIFO_DEPTH)+1  current occupancy.
REQ-015 SHALL have port err_illegal_op  output  1  one-cycle pulse on rejected opcode.

Function
REQ-016 SHALL set cmd_ready = (fifo_count < FIFO_DEPTH), independent of cmd_valid.
REQ-017 SHALL push {cmd_a,cmd_b,cmd_op} on edge where cmd_valid & cmd_ready & cmd_op <= 100.
REQ-018 SHALL, for cmd_valid & cmd_ready & cmd_op in 101..111, not push, and assert err_illegal_op for exactly the next cycle.
REQ-019 SHALL ignore cmd_valid when full; no overwrite, no error pulse.
REQ-020 SHALL use FSM states IDLE, DRIVE, HOLD.
REQ-021 IDLE: if fifo_count>0, pop head into alu_a/alu_b/alu_op, go DRIVE; else stay.
REQ-022 DRIVE (exactly one cycle): at next edge capture alu_result into rsp_result, alu_op into rsp_op, set rsp_valid=1, go HOLD.
REQ-023 HOLD: rsp_valid, rsp_result, rsp_op stable until rsp_valid & rsp_ready edge.
REQ-024 HOLD on handshake: rsp_valid cleared; if fifo_count>0 pop next head and go DRIVE same edge, else go IDLE.
REQ-025 alu_a/alu_b/alu_op SHALL change only on a pop edge; hold last values otherwise.
REQ-026 Latency: command pushed at edge N into empty FIFO with FSM IDLE -> pop at N+1, rsp_valid at N+2.
REQ-027 Throughput: one result per 2 cycles with rsp_ready held high.
REQ-028 Simultaneous push and pop SHALL leave fifo_count unchanged; push while full-and-popping is refused (cmd_ready already low).
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH; order strictly first-in first-out.
REQ-030 No arithmetic performed here; results are exactly 4-bit alu_result as presented.

Reset
REQ-031 rst high SHALL immediately force: FSM IDLE, FIFO empty (fifo_count=0, pointers 0), cmd_ready=1, alu_a/alu_b/alu_op=0, rsp_valid=0, rsp_result=0, rsp_op=0, err_illegal_op=0.
REQ-032 Reset mid-operation SHALL discard queued and in-flight commands; no rsp_valid until new commands pushed after rst deasserts.

Verification (bench models ALU: 4-bit wraparound)
REQ-033 Push (4,2,000) with rsp_ready=1 -> rsp_valid 2 cycles later, rsp_result=6, rsp_op=000.
REQ-034 Push back-to-back (7,3,001),(5,6,010),(5,6,011),(8,9,100) -> results 4,4,7,1 in order; fifo_count peaks correctly; cmd_ready low only at 4 entries.
REQ-035 Hold rsp_ready=0, push 5 commands -> 1 in HOLD + 4 queued, cmd_ready=0, 6th ignored; release -> all 5 results in order, none lost.
REQ-036 Push (3,3,110) -> err_illegal_op one-cycle pulse, fifo_count stays 0, no response.
REQ-037 Push (15,1,000) then (0,1,001) -> rsp_result 0 then 15 (wraparound).
REQ-038 Queue 3 commands, assert rst during DRIVE -> all outputs at reset values that cycle; after release, no stale response appears.
